// File: rtl/reg_dual_wr_arbiter.sv
// reg_dual_wr_arbiter
// Write-side scheduler for a dual-port 8-bit register that accepts only one
// port write per cycle. Each requester hands a write over a valid/ready
// handshake into its own one-entry holding buffer. One pending buffer is
// issued per cycle: the only pending one, or round-robin when both are
// pending. The register enable and data lines are driven from flops.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid_1/2 requester k offers a write
//   req_data_1/2  requester k write data
//   req_ready_1/2 requester k handshake ready (independent of req_valid_k)
//   enable        one-hot write enable: 01 = port 1, 10 = port 2, 00 = idle
//   data_out_1/2  data presented to register port 1/2 (held when not written)
//   conflict_cnt  saturating count of cycles with both buffers pending
module reg_dual_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_1,
  input  logic [DATA_WIDTH-1:0] req_data_1,
  output logic                  req_ready_1,
  input  logic                  req_valid_2,
  input  logic [DATA_WIDTH-1:0] req_data_2,
  output logic                  req_ready_2,
  output logic [1:0]            enable,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                  pending_1_p0;
  logic                  pending_2_p0;
  logic [DATA_WIDTH-1:0] buf_1_p0;
  logic [DATA_WIDTH-1:0] buf_2_p0;
  // 1 when port 2 was the most recent grant; reset to 1 so port 1 wins the first tie.
  logic                  last_grant_2;

  logic grant_1;
  logic grant_2;
  logic acc_1;
  logic acc_2;

  always_comb begin
    grant_1     = pending_1_p0 & (~pending_2_p0 | last_grant_2);
    grant_2     = pending_2_p0 & (~pending_1_p0 | ~last_grant_2);
    // A buffer being drained this cycle can take a new write at the same edge.
    req_ready_1 = ~pending_1_p0 | grant_1;
    req_ready_2 = ~pending_2_p0 | grant_2;
    acc_1       = req_valid_1 & req_ready_1;
    acc_2       = req_valid_2 & req_ready_2;
  end

  // Stage p0: holding buffers, one per requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_1_p0 <= 1'b0;
      pending_2_p0 <= 1'b0;
      buf_1_p0     <= '0;
      buf_2_p0     <= '0;
    end else begin
      if (acc_1) begin
        buf_1_p0     <= req_data_1;
        pending_1_p0 <= 1'b1;
      end else if (grant_1) begin
        pending_1_p0 <= 1'b0;
      end
      if (acc_2) begin
        buf_2_p0     <= req_data_2;
        pending_2_p0 <= 1'b1;
      end else if (grant_2) begin
        pending_2_p0 <= 1'b0;
      end
    end
  end

  // Stage p1: registered issue to the dual register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable       <= 2'b00;
      data_out_1   <= '0;
      data_out_2   <= '0;
      last_grant_2 <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      enable <= {grant_2, grant_1};
      if (grant_1) begin
        data_out_1   <= buf_1_p0;
        last_grant_2 <= 1'b0;
      end
      if (grant_2) begin
        data_out_2   <= buf_2_p0;
        last_grant_2 <= 1'b1;
      end
      if (pending_1_p0 && pending_2_p0) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end

endmodule

// File: doc/reg_dual_wr_arbiter.md
Name: reg_dual_wr_arbiter

Overview:
- Write-side scheduler for the dual 8-bit register (two data ports, 2-bit one-hot write enable; only one port may be written per cycle).
- Two independent requesters each hand over a write through a valid/ready handshake into a one-entry holding buffer.
- The block grants one pending write per cycle, round-robin on conflict, and drives the register's enable and data inputs from registers.
- It also counts conflict cycles for debug.

Parameters:
- DATA_WIDTH, 8, width of each data path.
- CNT_WIDTH, 8, width of the saturating conflict counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_1  in  1  requester 1 offers a write.
- req_data_1  in  DATA_WIDTH  requester 1 write data.
- req_ready_1  out  1  requester 1 write accepted this cycle when valid & ready.
- req_valid_2  in  1  requester 2 offers a write.
- req_data_2  in  DATA_WIDTH  requester 2 write data.
- req_ready_2  out  1  requester 2 handshake ready.
- enable  out  2  one-hot write enable to the dual register: 01 = port 1, 10 = port 2, 00 = idle.
- data_out_1  out  DATA_WIDTH  data to register port 1.
- data_out_2  out  DATA_WIDTH  data to register port 2.
- conflict_cnt  out  CNT_WIDTH  saturating count of cycles with both buffers pending.

Behaviour:
- Reset (asynchronous, rst_n low) sets:
  - enable = 00, data_out_1 = 0, data_out_2 = 0, conflict_cnt = 0.
  - pending_1 = pending_2 = 0, buffer data = 0.
  - last_grant = 2, so port 1 wins the first tie.
- Per-channel buffer k:
  - pending_k flag plus buf_k data register.
  - Accept happens at the rising edge where req_valid_k & req_ready_k; buf_k <= req_data_k and pending_k <= 1.
- Grant (combinational, from flops):
  - grant_1 = pending_1 & (~pending_2 | last_grant == 2).
  - grant_2 = pending_2 & (~pending_1 | last_grant == 1).
  - At most one grant is active.
- Ready:
  - req_ready_k = ~pending_k | grant_k.
  - A buffer being drained may be refilled in the same cycle.
  - Ready never depends on req_valid_k.
- Issue, at the edge ending a cycle with grant_k:
  - enable <= one-hot k, data_out_k <= buf_k, last_grant <= k.
  - pending_k <= 0 unless reloaded by a simultaneous accept, in which case pending_k stays 1 with the new data.
- Idle cycle (no grant): enable <= 00.
- data_out_1/2 hold their last value when not granted; data_out of the non-granted port never changes.
- enable is never 11, and is high for exactly one cycle per accepted write.
- Latency: accept edge E → enable asserted in the cycle after edge E+1 (earliest); register captures at edge E+2.
- Throughput:
  - One requester alone: one write per cycle sustained.
  - Both requesters streaming: strict alternation 1,2,1,2…
- Fairness: a pending write is granted within at most 2 cycles.
- conflict_cnt increments at each edge where pending_1 & pending_2; it saturates at all-ones and does not wrap.
- Reset mid-operation: pending writes are discarded and enable drops to 00 immediately (asynchronously). There is no write to the register in the reset cycle beyond what the register itself does.
- No data is ever lost or duplicated: the number of enable pulses per port equals the number of accepted handshakes on that port.

Test Plan:
- Reset check: hold rst_n low with random inputs → enable = 00, data_out = 0, req_ready_1 = req_ready_2 = 1, conflict_cnt = 0. Deassert rst_n, idle → enable stays 00.
- Single write: req_valid_1 = 1, req_data_1 = 0x3C for one cycle → exactly one cycle later enable = 01 and data_out_1 = 0x3C for one cycle; data_out_2 unchanged (0x00).
- Simultaneous first conflict: both valid in the same cycle with 0xA1 / 0xB2 → enable = 01 (0xA1) then 10 (0xB2) on consecutive cycles; conflict_cnt = 1.
- Streaming both ports: both valid continuously for 10 handshakes each (data 0x10.., 0x20..) → enable alternates 01/10 with in-order data per port; each port's ready pattern is 1,0,1,0 after the first accept; no 11 ever.
- Single-port streaming: req_valid_2 held high for 8 cycles with data 0x00..0x07 → req_ready_2 constant 1; enable = 10 for 8 consecutive cycles carrying 0x00..0x07.
- Reset mid-operation, plus counter saturation:
  - Assert rst_n low while both buffers are pending → enable 00 immediately; after release, no stale write appears.
  - Force 300 conflict cycles with CNT_WIDTH = 8 → conflict_cnt = 0xFF, not 0x2C.
